// File: rtl/instbuf_flow_ctrl.sv
// Occupancy and flow controller for the decoded-instruction buffer.
// Owns head/tail/count, compacts sparse decode lanes and sequences flush recovery.
module instbuf_flow_ctrl #(
  parameter int unsigned QUEUE_DEPTH    = 32,
  parameter int unsigned QUEUE_LOG      = 5,
  parameter int unsigned FETCH_WIDTH    = 8,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic                             stall_i,
  input  logic                             decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]           decodedVector_i,
  output logic [FETCH_WIDTH-1:0]           writeEnable_o,
  output logic [FETCH_WIDTH*QUEUE_LOG-1:0] writeAddr_o,
  output logic [QUEUE_LOG-1:0]             readAddrBase_o,
  output logic                             dispatchValid_o,
  output logic                             stallFetch_o,
  output logic [QUEUE_LOG:0]               instCount_o,
  output logic                             flushBusy_o
);

  localparam int unsigned CNT_W        = QUEUE_LOG + 1;
  localparam int unsigned LANE_W       = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned FC_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned STALL_THRESH = QUEUE_DEPTH - FETCH_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [QUEUE_LOG-1:0] head_q, head_d;
  logic [QUEUE_LOG-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic                 accept;
  logic                 fire;
  logic [LANE_W-1:0]    lane_off;
  logic [LANE_W-1:0]    num_in;

  // Lane compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    lane_off        = '0;
    writeAddr_o     = '0;
    stallFetch_o    = (state_q != ST_RUN) | (count_q > CNT_W'(STALL_THRESH));
    accept          = decodeReady_i & ~stallFetch_o & ~flush_i;
    writeEnable_o   = accept ? decodedVector_i : '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      writeAddr_o[k*QUEUE_LOG +: QUEUE_LOG] = tail_q + QUEUE_LOG'(lane_off);
      lane_off = lane_off + LANE_W'(decodedVector_i[k]);
    end
    num_in          = accept ? lane_off : '0;
    dispatchValid_o = (state_q == ST_RUN) & (count_q >= CNT_W'(DISPATCH_WIDTH));
    fire            = dispatchValid_o & ~stall_i & ~flush_i;
  end

  assign readAddrBase_o = head_q;
  assign instCount_o    = count_q;
  assign flushBusy_o    = (state_q == ST_FLUSH);

  // Next-state: flush overrides everything; otherwise pointers and count track writes/dispatch.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i) begin
      state_d     = ST_FLUSH;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
    end else begin
      tail_d  = tail_q + QUEUE_LOG'(num_in);
      head_d  = fire ? head_q + QUEUE_LOG'(DISPATCH_WIDTH) : head_q;
      count_d = count_q + CNT_W'(num_in) - (fire ? CNT_W'(DISPATCH_WIDTH) : CNT_W'(0));
      case (state_q)
        ST_INIT: state_d = ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Structural invariants of the circular buffer.
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= CNT_W'(QUEUE_DEPTH));
  a_ptr_invariant: assert property (@(posedge clk) disable iff (!reset)
    tail_q == head_q + QUEUE_LOG'(count_q));
  a_no_write_stalled: assert property (@(posedge clk) disable iff (!reset)
    stallFetch_o |-> (writeEnable_o == '0));

endmodule

// File: tb/tb_instbuf_flow_ctrl.sv
// Self-checking bench for instbuf_flow_ctrl: reference model plus write-address scoreboard.
module tb_instbuf_flow_ctrl;

  localparam int QD = 32;
  localparam int QL = 5;
  localparam int FW = 8;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        decodeReady_i = 1'b0;
  logic [7:0]  decodedVector_i = 8'h00;
  logic [7:0]  writeEnable_o;
  logic [39:0] writeAddr_o;
  logic [4:0]  readAddrBase_o;
  logic        dispatchValid_o;
  logic        stallFetch_o;
  logic [5:0]  instCount_o;
  logic        flushBusy_o;

  always #5 clk = ~clk;

  instbuf_flow_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .stall_i         (stall_i),
    .decodeReady_i   (decodeReady_i),
    .decodedVector_i (decodedVector_i),
    .writeEnable_o   (writeEnable_o),
    .writeAddr_o     (writeAddr_o),
    .readAddrBase_o  (readAddrBase_o),
    .dispatchValid_o (dispatchValid_o),
    .stallFetch_o    (stallFetch_o),
    .instCount_o     (instCount_o),
    .flushBusy_o     (flushBusy_o)
  );

  typedef struct {
    int lane;
    int addr;
  } wr_t;

  wr_t sb_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  // Model state: current cycle (m_*) and value after the coming edge (n_*); state 0=INIT 1=RUN 2=FLUSH.
  int m_head, m_tail, m_count, m_state, m_fcnt;
  int n_head = 0, n_tail = 0, n_count = 0, n_state = 0, n_fcnt = 0;
  logic [7:0] e_we;
  logic       e_stall, e_dv, e_busy;
  int         e_cnt, e_head;

  task automatic drive(input logic rst_v, input logic fl_v, input logic st_v,
                       input logic rdy_v, input logic [7:0] vec_v);
    int   off;
    int   num;
    logic acc;
    logic fire;
    @(negedge clk);
    m_head = n_head; m_tail = n_tail; m_count = n_count; m_state = n_state; m_fcnt = n_fcnt;
    if (!rst_v) begin
      m_head = 0; m_tail = 0; m_count = 0; m_state = 0; m_fcnt = 0;
    end
    reset = rst_v; flush_i = fl_v; stall_i = st_v; decodeReady_i = rdy_v; decodedVector_i = vec_v;
    sb_q.delete();
    e_stall = (m_state != 1) || (m_count > QD - FW);
    acc     = rdy_v && !e_stall && !fl_v;
    e_we    = 8'h00;
    off     = 0;
    for (int k = 0; k < FW; k++) begin
      if (vec_v[k]) begin
        if (acc) begin
          e_we[k] = 1'b1;
          sb_q.push_back('{k, (m_tail + off) % QD});
        end
        off++;
      end
    end
    num    = acc ? off : 0;
    e_dv   = (m_state == 1) && (m_count >= DW);
    fire   = e_dv && !st_v && !fl_v;
    e_busy = (m_state == 2);
    e_cnt  = m_count;
    e_head = m_head;
    n_head = m_head; n_tail = m_tail; n_count = m_count; n_state = m_state; n_fcnt = m_fcnt;
    if (rst_v && fl_v) begin
      n_head = 0; n_tail = 0; n_count = 0; n_state = 2; n_fcnt = 1;
    end else if (rst_v) begin
      n_tail  = (m_tail + num) % QD;
      n_head  = fire ? (m_head + DW) % QD : m_head;
      n_count = m_count + num - (fire ? DW : 0);
      if (m_state == 0) n_state = 1;
      else if (m_state == 2) begin
        if (m_fcnt == 0) n_state = 1;
        else n_fcnt = m_fcnt - 1;
      end
    end
    #1;
  endtask

  task automatic flush_recover();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      n_total++;
      if (stallFetch_o !== 1'b1 || writeEnable_o !== 8'h00)
        $display("FAIL reset_hold: stall=%b we=%h, want stall=1 we=00", stallFetch_o, writeEnable_o);
      else n_pass++;
      n_total++;
      if (instCount_o !== 6'd0 || readAddrBase_o !== 5'd0 || dispatchValid_o !== 1'b0 || flushBusy_o !== 1'b0)
        $display("FAIL reset_outs: cnt=%0d head=%0d dv=%b busy=%b, want 0", instCount_o, readAddrBase_o,
                 dispatchValid_o, flushBusy_o);
      else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++;
    if (stallFetch_o !== 1'b1) $display("FAIL init_stall: got %b want 1", stallFetch_o);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++;
    if (stallFetch_o !== 1'b0 || dispatchValid_o !== 1'b0 || instCount_o !== 6'd0)
      $display("FAIL run_entry: stall=%b dv=%b cnt=%0d, want 0 0 0", stallFetch_o, dispatchValid_o, instCount_o);
    else n_pass++;
  endtask

  task automatic test_sparse();
    wr_t wr;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'b1010_0101);
    n_total++;
    if (writeEnable_o !== 8'hA5 || writeEnable_o !== e_we)
      $display("FAIL sparse_we: got %h want a5", writeEnable_o);
    else n_pass++;
    n_total++;
    if (writeAddr_o[7*QL +: QL] !== 5'd3) $display("FAIL sparse_lane7: got %0d want 3", writeAddr_o[7*QL +: QL]);
    else n_pass++;
    while (sb_q.size() != 0) begin
      wr = sb_q.pop_front();
      n_total++;
      if (writeAddr_o[wr.lane*QL +: QL] !== 5'(wr.addr))
        $display("FAIL sparse_addr lane %0d: got %0d want %0d", wr.lane, writeAddr_o[wr.lane*QL +: QL], wr.addr);
      else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
    n_total++;
    if (instCount_o !== 6'd4 || dispatchValid_o !== 1'b1)
      $display("FAIL sparse_count: cnt=%0d dv=%b, want 4 1", instCount_o, dispatchValid_o);
    else n_pass++;
    while (sb_q.size() != 0) begin
      wr = sb_q.pop_front();
      n_total++;
      if (writeAddr_o[wr.lane*QL +: QL] !== 5'(wr.addr) || wr.addr != 4)
        $display("FAIL sparse_tail lane %0d: got %0d want 4", wr.lane, writeAddr_o[wr.lane*QL +: QL]);
      else n_pass++;
    end
  endtask

  task automatic test_full_bw();
    wr_t wr;
    flush_recover();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
      n_total++;
      if (writeEnable_o !== e_we || stallFetch_o !== e_stall || instCount_o !== 6'(i * 8))
        $display("FAIL full_bw step %0d: we=%h stall=%b cnt=%0d, want %h %b %0d", i, writeEnable_o,
                 stallFetch_o, instCount_o, e_we, e_stall, i * 8);
      else n_pass++;
      while (sb_q.size() != 0) begin
        wr = sb_q.pop_front();
        n_total++;
        if (writeAddr_o[wr.lane*QL +: QL] !== 5'(wr.addr))
          $display("FAIL full_bw_addr lane %0d: got %0d want %0d", wr.lane, writeAddr_o[wr.lane*QL +: QL], wr.addr);
        else n_pass++;
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++;
    if (instCount_o !== 6'd28 || stallFetch_o !== 1'b1)
      $display("FAIL full_bw_28: cnt=%0d stall=%b, want 28 1", instCount_o, stallFetch_o);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
    n_total++;
    if (instCount_o !== 6'd24 || stallFetch_o !== 1'b0 || writeEnable_o !== 8'h01)
      $display("FAIL full_bw_24: cnt=%0d stall=%b we=%h, want 24 0 01", instCount_o, stallFetch_o, writeEnable_o);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    n_total++;
    if (instCount_o !== 6'd25 || stallFetch_o !== 1'b1 || writeEnable_o !== 8'h00)
      $display("FAIL full_bw_25: cnt=%0d stall=%b we=%h, want 25 1 00", instCount_o, stallFetch_o, writeEnable_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    wr_t wr;
    flush_recover();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    n_total++;
    if (readAddrBase_o !== 5'd28 || instCount_o !== 6'd0)
      $display("FAIL wrap_start: head=%0d cnt=%0d, want 28 0", readAddrBase_o, instCount_o);
    else n_pass++;
    n_total++;
    if (writeAddr_o[4*QL +: QL] !== 5'd0) $display("FAIL wrap_lane4: got %0d want 0", writeAddr_o[4*QL +: QL]);
    else n_pass++;
    while (sb_q.size() != 0) begin
      wr = sb_q.pop_front();
      n_total++;
      if (writeAddr_o[wr.lane*QL +: QL] !== 5'(wr.addr))
        $display("FAIL wrap_addr lane %0d: got %0d want %0d", wr.lane, writeAddr_o[wr.lane*QL +: QL], wr.addr);
      else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++;
    if (readAddrBase_o !== 5'd0 || instCount_o !== 6'd4)
      $display("FAIL wrap_disp1: head=%0d cnt=%0d, want 0 4", readAddrBase_o, instCount_o);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++;
    if (readAddrBase_o !== 5'd4 || instCount_o !== 6'd0 || dispatchValid_o !== 1'b0)
      $display("FAIL wrap_disp2: head=%0d cnt=%0d dv=%b, want 4 0 0", readAddrBase_o, instCount_o, dispatchValid_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr_t wr;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h0B);
    n_total++;
    if (writeEnable_o !== 8'h0B || dispatchValid_o !== 1'b1 || instCount_o !== 6'd12)
      $display("FAIL b2b_in: we=%h dv=%b cnt=%0d, want 0b 1 12", writeEnable_o, dispatchValid_o, instCount_o);
    else n_pass++;
    while (sb_q.size() != 0) begin
      wr = sb_q.pop_front();
      n_total++;
      if (writeAddr_o[wr.lane*QL +: QL] !== 5'(wr.addr))
        $display("FAIL b2b_addr lane %0d: got %0d want %0d", wr.lane, writeAddr_o[wr.lane*QL +: QL], wr.addr);
      else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    n_total++;
    if (instCount_o !== 6'd11 || readAddrBase_o !== 5'd8 || readAddrBase_o !== 5'(e_head))
      $display("FAIL b2b_out: cnt=%0d head=%0d, want 11 8", instCount_o, readAddrBase_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    flush_recover();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    n_total++;
    if (writeEnable_o !== 8'h00 || instCount_o !== 6'd20)
      $display("FAIL flush_we: we=%h cnt=%0d, want 00 20", writeEnable_o, instCount_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
      n_total++;
      if (flushBusy_o !== (i < 2) || stallFetch_o !== (i < 2) || instCount_o !== 6'd0 ||
          readAddrBase_o !== 5'd0 || flushBusy_o !== e_busy)
        $display("FAIL flush_rec %0d: busy=%b stall=%b cnt=%0d head=%0d, want busy=stall=%b cnt=0 head=0",
                 i, flushBusy_o, stallFetch_o, instCount_o, readAddrBase_o, i < 2);
      else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    n_total++;
    if (flushBusy_o !== 1'b1) $display("FAIL flush2_at: busy=%b want 1", flushBusy_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      n_total++;
      if (flushBusy_o !== (i < 2) || stallFetch_o !== (i < 2))
        $display("FAIL flush2_rec %0d: busy=%b stall=%b, want %b", i, flushBusy_o, stallFetch_o, i < 2);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (instCount_o !== 6'd0 || readAddrBase_o !== 5'd0 || stallFetch_o !== 1'b1 || dispatchValid_o !== 1'b0)
      $display("FAIL async_reset: cnt=%0d head=%0d stall=%b dv=%b, want 0 0 1 0", instCount_o, readAddrBase_o,
               stallFetch_o, dispatchValid_o);
    else n_pass++;
    n_head = 0; n_tail = 0; n_count = 0; n_state = 0; n_fcnt = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
    n_total++;
    if (stallFetch_o !== 1'b0 || writeEnable_o !== 8'h03 || writeAddr_o[1*QL +: QL] !== 5'd1)
      $display("FAIL post_reset: stall=%b we=%h addr1=%0d, want 0 03 1", stallFetch_o, writeEnable_o,
               writeAddr_o[1*QL +: QL]);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sparse();
    test_full_bw();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
